// File: rtl/sccb_master.sv
// SCCB (camera control bus) 3-phase write master: start, slave/reg/data bytes, stop.
// Open-drain pins only ever pull low or release; the pull-ups live on the board.
module sccb_master #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned SCCB_FREQ = 400_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] slave_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       ready,
  output logic       one_phase_done,
  output logic       done,
  inout  wire        siod,
  output wire        sioc
);

  localparam int unsigned Q_RAW = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int unsigned Q     = (Q_RAW == 0) ? 1 : Q_RAW;
  localparam int unsigned CNT_W = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(Q - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_PHASE, S_STOP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       seg_q, seg_d;
  logic [3:0]       bit_q, bit_d;
  logic [1:0]       phase_q, phase_d;
  logic [23:0]      sh_q, sh_d;
  logic             siod_low_q, siod_low_d;
  logic             sioc_low_q, sioc_low_d;
  logic             ready_q, ready_d;
  logic             opd_q, opd_d;
  logic             done_q, done_d;
  logic             tick;

  assign tick = (cnt_q == CNT_MAX);

  // Sequencing: segments advance on tick; bytes shift out MSB first from one 24-bit register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    sh_d    = sh_q;
    opd_d   = 1'b0;
    done_d  = 1'b0;

    if (state_q != S_IDLE && state_q != S_DONE) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          cnt_d   = '0;
          seg_d   = '0;
          bit_d   = '0;
          phase_d = '0;
          sh_d    = {slave_addr, reg_addr, reg_data};
        end
      end
      S_START: begin
        if (tick) begin
          if (seg_q == 2'd1) begin
            state_d = S_PHASE;
            seg_d   = '0;
          end else begin
            seg_d = seg_q + 2'd1;
          end
        end
      end
      S_PHASE: begin
        if (tick) begin
          seg_d = seg_q + 2'd1;
          if (seg_q == 2'd3) begin
            if (bit_q == 4'd8) begin
              opd_d = 1'b1;
              bit_d = '0;
              if (phase_q == 2'd2) begin
                state_d = S_STOP;
              end else begin
                phase_d = phase_q + 2'd1;
              end
            end else begin
              bit_d = bit_q + 4'd1;
              sh_d  = {sh_q[22:0], 1'b0};
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (seg_q == 2'd2) begin
            state_d = S_DONE;
            seg_d   = '0;
            done_d  = 1'b1;
          end else begin
            seg_d = seg_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pin levels are derived from the upcoming state so they register in step with it.
    siod_low_d = 1'b0;
    sioc_low_d = 1'b0;
    unique case (state_d)
      S_START: begin
        siod_low_d = 1'b1;
        sioc_low_d = (seg_d == 2'd1);
      end
      S_PHASE: begin
        sioc_low_d = (seg_d == 2'd0) || (seg_d == 2'd3);
        siod_low_d = (bit_d != 4'd8) && !sh_d[23];
      end
      S_STOP: begin
        siod_low_d = (seg_d != 2'd2);
        sioc_low_d = (seg_d == 2'd0);
      end
      default: begin
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      seg_q      <= '0;
      bit_q      <= '0;
      phase_q    <= '0;
      sh_q       <= '0;
      siod_low_q <= 1'b0;
      sioc_low_q <= 1'b0;
      ready_q    <= 1'b1;
      opd_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      sh_q       <= sh_d;
      siod_low_q <= siod_low_d;
      sioc_low_q <= sioc_low_d;
      ready_q    <= ready_d;
      opd_q      <= opd_d;
      done_q     <= done_d;
    end
  end

  assign siod           = siod_low_q ? 1'b0 : 1'bz;
  assign sioc           = sioc_low_q ? 1'b0 : 1'bz;
  assign ready          = ready_q;
  assign one_phase_done = opd_q;
  assign done           = done_q;

endmodule

// File: doc/sccb_master.md
SCCB_MASTER -- requirements
Module: sccb_master

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter SCCB_FREQ, default 400_000, meaning the sioc frequency in Hz.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic sits on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request a 3-phase write; sampled only while ready=1.
REQ-006 SHALL have port slave_addr, input, 8 bits: phase-1 byte (camera write address, 8'h42).
REQ-007 SHALL have port reg_addr, input, 8 bits: phase-2 byte (camera register address).
REQ-008 SHALL have port reg_data, input, 8 bits: phase-3 byte (camera register data).
REQ-009 SHALL have port ready, output, 1 bit: idle and able to accept start.
REQ-010 SHALL have port one_phase_done, output, 1 bit: 1-clk pulse at the end of each 9-bit phase.
REQ-011 SHALL have port done, output, 1 bit: 1-clk pulse when the stop condition completes.
REQ-012 SHALL have port siod, inout, 1 bit: open-drain SCCB data; drives 0 or 1'bz, never 1.
REQ-013 SHALL have port sioc, output, 1 bit: open-drain SCCB clock; drives 0 or 1'bz, never 1.

Function
REQ-014 SHALL generate an internal tick every Q = CLK_FREQ/(4*SCCB_FREQ) clk cycles using integer division (Q=62 at the defaults); a 1-tick segment lasts Q clks.
REQ-015 SHALL use FSM states IDLE, START, PHASE, STOP and DONE.
REQ-016 IDLE behaviour: ready=1, siod=z, sioc=z.
- On start=1 the FSM SHALL latch all three bytes and go to START.
- ready SHALL be 0 from the next clk.
REQ-017 START behaviour: 1 tick with siod=0 and sioc=z, then 1 tick with siod=0 and sioc=0, then go to PHASE.
REQ-018 PHASE SHALL send 3 phases in order: slave_addr, then reg_addr, then reg_data.
- Each phase is 9 bits: 8 data bits MSB first, then 1 don't-care bit.
REQ-019 Each bit SHALL take 4 ticks: sioc=0, sioc=z, sioc=z, sioc=0.
- siod is updated at the start of tick 0 only and held through tick 3.
- A data bit of 1 SHALL drive siod=z; a data bit of 0 SHALL drive siod=0.
- The 9th bit SHALL drive siod=z; the slave response is not checked.
REQ-020 one_phase_done SHALL pulse high for exactly 1 clk on the clk after the 9th bit of each phase ends, giving 3 pulses per transaction.
REQ-021 STOP behaviour, each segment 1 tick: siod=0 with sioc=0; then siod=0 with sioc=z; then siod=z with sioc=z; then go to DONE.
REQ-022 DONE SHALL pulse done for 1 clk and go to IDLE; ready SHALL be 1 on the following clk.
REQ-023 A transaction SHALL last 113 ticks (2 start + 108 bits + 3 stop) plus at most 2 clks.
REQ-024 start asserted while ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-025 Changes to slave_addr, reg_addr or reg_data after latching SHALL NOT affect the transaction in progress.
REQ-026 start held high continuously SHALL begin a new transaction on the first clk ready=1, back-to-back.
REQ-027 The tick counter SHALL restart at 0 on every IDLE-to-START transition.

Reset
REQ-028 On rst=1, immediately and asynchronously, the block SHALL set: state=IDLE, siod=z, sioc=z, ready=1, one_phase_done=0, done=0, all counters=0.
REQ-029 rst asserted mid-transaction SHALL abort the transaction without generating a stop condition; no done pulse SHALL follow.

Verification
REQ-030 Reset then idle: pulse rst, hold start=0 for 1000 clks -> siod===z, sioc===z, ready=1, no pulses.
REQ-031 Single write: bytes 8'h42, 8'h12, 8'h80 -> decoding sioc rising edges gives 0x42, 0x12, 0x80 MSB first, each followed by a z bit.
- Exactly 3 one_phase_done pulses, then 1 done pulse.
- Start-to-done between 113*62 and 113*62+2 clks.
REQ-032 Bus conditions: check at START and STOP -> siod falls while sioc=z (start condition) and siod rises to z while sioc=z (stop condition).
- siod never changes while sioc=z during PHASE.
REQ-033 Busy start: pulse start again mid-phase-2 -> ignored; one done pulse only; ready stays 0 until done.
REQ-034 Mid-transaction reset: assert rst during phase 2 bit 4 -> siod and sioc are z within the same clk, ready=1, no done pulse.
- A subsequent write of 8'h42, 8'h3A, 8'h04 completes correctly.
REQ-035 Back-to-back: hold start=1 and change the bytes after each done over 77 writes -> 231 one_phase_done pulses and 77 done pulses, all bytes decoded correctly.
